// File: rtl/wb_arbiter2.sv
// Two-master Wishbone classic arbiter with round-robin tie-break and an ACK watchdog.
// The grant is held for the owner's whole CYC; a slave that never terminates is aborted with ERR.
module wb_arbiter2 #(
    parameter int WISHBONE_ADDR_WIDTH = 32,
    parameter int WISHBONE_BUS_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES      = 255
) (
    input  logic                              CLK_I,
    input  logic                              RST_I,

    input  logic                              M0_CYC_I,
    input  logic                              M0_STB_I,
    input  logic                              M0_WE_I,
    input  logic [WISHBONE_ADDR_WIDTH-1:0]    M0_ADR_I,
    input  logic [WISHBONE_BUS_WIDTH-1:0]     M0_DAT_I,
    input  logic [WISHBONE_BUS_WIDTH/8-1:0]   M0_SEL_I,
    output logic [WISHBONE_BUS_WIDTH-1:0]     M0_DAT_O,
    output logic                              M0_ACK_O,
    output logic                              M0_ERR_O,

    input  logic                              M1_CYC_I,
    input  logic                              M1_STB_I,
    input  logic                              M1_WE_I,
    input  logic [WISHBONE_ADDR_WIDTH-1:0]    M1_ADR_I,
    input  logic [WISHBONE_BUS_WIDTH-1:0]     M1_DAT_I,
    input  logic [WISHBONE_BUS_WIDTH/8-1:0]   M1_SEL_I,
    output logic [WISHBONE_BUS_WIDTH-1:0]     M1_DAT_O,
    output logic                              M1_ACK_O,
    output logic                              M1_ERR_O,

    output logic                              S_CYC_O,
    output logic                              S_STB_O,
    output logic                              S_WE_O,
    output logic [WISHBONE_ADDR_WIDTH-1:0]    S_ADR_O,
    output logic [WISHBONE_BUS_WIDTH-1:0]     S_DAT_O,
    output logic [WISHBONE_BUS_WIDTH/8-1:0]   S_SEL_O,
    input  logic [WISHBONE_BUS_WIDTH-1:0]     S_DAT_I,
    input  logic                              S_ACK_I,
    input  logic                              S_ERR_I,

    output logic [1:0]                        GNT_O,
    output logic                              TIMEOUT_O
);

    // A zero timeout still needs a legal one-bit counter even though it never counts.
    localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);
    localparam bit WD_ENABLE = (TIMEOUT_CYCLES > 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_ABORT
    } state_t;

    state_t            state_reg, state_next;
    logic              owner_reg, owner_next;
    logic              last_reg, last_next;
    logic [WD_W-1:0]   wd_cnt_reg, wd_cnt_next;
    logic              timeout_reg, timeout_next;

    logic                            own_cyc;
    logic                            own_stb;
    logic                            own_we;
    logic [WISHBONE_ADDR_WIDTH-1:0]  own_adr;
    logic [WISHBONE_BUS_WIDTH-1:0]   own_dat;
    logic [WISHBONE_BUS_WIDTH/8-1:0] own_sel;
    logic                            in_grant;
    logic                            wd_hit;

    assign own_cyc = owner_reg ? M1_CYC_I : M0_CYC_I;
    assign own_stb = owner_reg ? M1_STB_I : M0_STB_I;
    assign own_we  = owner_reg ? M1_WE_I  : M0_WE_I;
    assign own_adr = owner_reg ? M1_ADR_I : M0_ADR_I;
    assign own_dat = owner_reg ? M1_DAT_I : M0_DAT_I;
    assign own_sel = owner_reg ? M1_SEL_I : M0_SEL_I;

    assign in_grant = (state_reg == ST_GRANT);

    // A termination arriving on the threshold cycle takes priority over the abort.
    assign wd_hit = WD_ENABLE && in_grant && own_stb && (wd_cnt_reg == WD_MAX)
                    && !S_ACK_I && !S_ERR_I;

    assign M0_DAT_O  = S_DAT_I;
    assign M1_DAT_O  = S_DAT_I;
    assign TIMEOUT_O = timeout_reg;
    assign GNT_O     = (state_reg == ST_IDLE) ? 2'b00 : {owner_reg, ~owner_reg};

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_reg   <= ST_IDLE;
            owner_reg   <= 1'b0;
            last_reg    <= 1'b1;
            wd_cnt_reg  <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            owner_reg   <= owner_next;
            last_reg    <= last_next;
            wd_cnt_reg  <= wd_cnt_next;
            timeout_reg <= timeout_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        owner_next   = owner_reg;
        last_next    = last_reg;
        wd_cnt_next  = '0;
        timeout_next = wd_hit;

        unique case (state_reg)
            ST_IDLE: begin
                if (M0_CYC_I && M1_CYC_I) begin
                    owner_next = ~last_reg;
                    state_next = ST_GRANT;
                end else if (M0_CYC_I) begin
                    owner_next = 1'b0;
                    state_next = ST_GRANT;
                end else if (M1_CYC_I) begin
                    owner_next = 1'b1;
                    state_next = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!own_cyc) begin
                    state_next = ST_IDLE;
                    last_next  = owner_reg;
                end else if (wd_hit) begin
                    state_next = ST_ABORT;
                end else if (WD_ENABLE && own_stb && !S_ACK_I && !S_ERR_I) begin
                    wd_cnt_next = wd_cnt_reg + WD_W'(1);
                end
            end
            ST_ABORT: begin
                if (!own_cyc) begin
                    state_next = ST_IDLE;
                    last_next  = owner_reg;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        S_CYC_O  = 1'b0;
        S_STB_O  = 1'b0;
        S_WE_O   = 1'b0;
        S_ADR_O  = '0;
        S_DAT_O  = '0;
        S_SEL_O  = '0;
        M0_ACK_O = 1'b0;
        M0_ERR_O = 1'b0;
        M1_ACK_O = 1'b0;
        M1_ERR_O = 1'b0;

        if (in_grant) begin
            S_CYC_O = own_cyc;
            S_STB_O = own_stb;
            S_WE_O  = own_we;
            S_ADR_O = own_adr;
            S_DAT_O = own_dat;
            S_SEL_O = own_sel;
            if (owner_reg) begin
                M1_ACK_O = S_ACK_I;
                M1_ERR_O = S_ERR_I | wd_hit;
            end else begin
                M0_ACK_O = S_ACK_I;
                M0_ERR_O = S_ERR_I | wd_hit;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2: grant, round-robin, watchdog abort, ACK/timeout race, async reset.
module tb_wb_arbiter2;

    localparam int AW = 32;
    localparam int BW = 32;

    logic            CLK_I = 1'b0;
    logic            RST_I;
    logic            M0_CYC_I, M0_STB_I, M0_WE_I;
    logic [AW-1:0]   M0_ADR_I;
    logic [BW-1:0]   M0_DAT_I;
    logic [BW/8-1:0] M0_SEL_I;
    logic [BW-1:0]   M0_DAT_O;
    logic            M0_ACK_O, M0_ERR_O;
    logic            M1_CYC_I, M1_STB_I, M1_WE_I;
    logic [AW-1:0]   M1_ADR_I;
    logic [BW-1:0]   M1_DAT_I;
    logic [BW/8-1:0] M1_SEL_I;
    logic [BW-1:0]   M1_DAT_O;
    logic            M1_ACK_O, M1_ERR_O;
    logic            S_CYC_O, S_STB_O, S_WE_O;
    logic [AW-1:0]   S_ADR_O;
    logic [BW-1:0]   S_DAT_O;
    logic [BW/8-1:0] S_SEL_O;
    logic [BW-1:0]   S_DAT_I;
    logic            S_ACK_I, S_ERR_I;
    logic [1:0]      GNT_O;
    logic            TIMEOUT_O;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 CLK_I = ~CLK_I;

    wb_arbiter2 #(
        .WISHBONE_ADDR_WIDTH(AW),
        .WISHBONE_BUS_WIDTH (BW),
        .TIMEOUT_CYCLES     (8)
    ) dut (
        .CLK_I    (CLK_I),
        .RST_I    (RST_I),
        .M0_CYC_I (M0_CYC_I),
        .M0_STB_I (M0_STB_I),
        .M0_WE_I  (M0_WE_I),
        .M0_ADR_I (M0_ADR_I),
        .M0_DAT_I (M0_DAT_I),
        .M0_SEL_I (M0_SEL_I),
        .M0_DAT_O (M0_DAT_O),
        .M0_ACK_O (M0_ACK_O),
        .M0_ERR_O (M0_ERR_O),
        .M1_CYC_I (M1_CYC_I),
        .M1_STB_I (M1_STB_I),
        .M1_WE_I  (M1_WE_I),
        .M1_ADR_I (M1_ADR_I),
        .M1_DAT_I (M1_DAT_I),
        .M1_SEL_I (M1_SEL_I),
        .M1_DAT_O (M1_DAT_O),
        .M1_ACK_O (M1_ACK_O),
        .M1_ERR_O (M1_ERR_O),
        .S_CYC_O  (S_CYC_O),
        .S_STB_O  (S_STB_O),
        .S_WE_O   (S_WE_O),
        .S_ADR_O  (S_ADR_O),
        .S_DAT_O  (S_DAT_O),
        .S_SEL_O  (S_SEL_O),
        .S_DAT_I  (S_DAT_I),
        .S_ACK_I  (S_ACK_I),
        .S_ERR_I  (S_ERR_I),
        .GNT_O    (GNT_O),
        .TIMEOUT_O(TIMEOUT_O)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK_I);
    endtask

    task automatic drop_masters();
        M0_CYC_I = 0; M0_STB_I = 0; M0_WE_I = 0;
        M1_CYC_I = 0; M1_STB_I = 0; M1_WE_I = 0;
    endtask

    initial begin
        RST_I = 1'b1;
        drop_masters();
        M0_ADR_I = '0; M0_DAT_I = '0; M0_SEL_I = '0;
        M1_ADR_I = '0; M1_DAT_I = '0; M1_SEL_I = '0;
        S_DAT_I = '0; S_ACK_I = 0; S_ERR_I = 0;

        // Reset state
        #23;
        check("rst_gnt", GNT_O, 2'b00);
        check("rst_scyc", S_CYC_O, 0);
        check("rst_timeout", TIMEOUT_O, 0);
        #4 RST_I = 1'b0;
        $display("[TB] reset state checked");

        // Single M1 write
        next_cycle();
        M1_CYC_I = 1; M1_STB_I = 1; M1_WE_I = 1;
        M1_ADR_I = 32'h100; M1_DAT_I = 32'hDEADBEEF; M1_SEL_I = 4'hF;
        sample();
        check("t1_idle_scyc", S_CYC_O, 0);
        next_cycle(); sample();
        check("t1_scyc", S_CYC_O, 1);
        check("t1_sadr", S_ADR_O, 32'h100);
        check("t1_sdat", S_DAT_O, 32'hDEADBEEF);
        check("t1_ssel", S_SEL_O, 4'hF);
        check("t1_swe", S_WE_O, 1);
        check("t1_gnt", GNT_O, 2'b10);
        check("t1_ack_before", M1_ACK_O, 0);
        next_cycle();
        S_ACK_I = 1; S_DAT_I = 32'h12345678;
        sample();
        check("t1_m1_ack", M1_ACK_O, 1);
        check("t1_m0_ack", M0_ACK_O, 0);
        check("t1_m1_dat", M1_DAT_O, 32'h12345678);
        next_cycle();
        S_ACK_I = 0; drop_masters();
        sample();
        check("t1_release_scyc", S_CYC_O, 0);
        next_cycle(); sample();
        check("t1_idle_gnt", GNT_O, 2'b00);
        $display("[TB] single M1 write done");

        // Tie after reset: M0 first, then M1 after one dead cycle
        next_cycle();
        M0_CYC_I = 1; M0_STB_I = 1; M0_ADR_I = 32'h200;
        M1_CYC_I = 1; M1_STB_I = 1; M1_ADR_I = 32'h300; M1_WE_I = 0;
        next_cycle(); sample();
        check("t2_gnt_m0", GNT_O, 2'b01);
        check("t2_sadr_m0", S_ADR_O, 32'h200);
        next_cycle();
        S_ACK_I = 1;
        sample();
        check("t2_m0_ack", M0_ACK_O, 1);
        check("t2_nonowner_ack", M1_ACK_O, 0);
        next_cycle();
        S_ACK_I = 0; M0_CYC_I = 0; M0_STB_I = 0;
        sample();
        check("t2_gnt_hold", GNT_O, 2'b01);
        next_cycle(); sample();
        check("t2_dead_gnt", GNT_O, 2'b00);
        check("t2_dead_scyc", S_CYC_O, 0);
        next_cycle(); sample();
        check("t2_gnt_m1", GNT_O, 2'b10);
        check("t2_scyc_m1", S_CYC_O, 1);
        check("t2_sadr_m1", S_ADR_O, 32'h300);
        next_cycle();
        drop_masters();
        next_cycle();
        $display("[TB] tie after reset done");

        // Repeated contention alternates M0, M1, M0, M1
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            M0_CYC_I = 1; M0_STB_I = 1; M1_CYC_I = 1; M1_STB_I = 1;
            next_cycle();
            drop_masters();
            sample();
            check($sformatf("t3_rr_%0d", i), GNT_O, (i % 2 == 0) ? 2'b01 : 2'b10);
        end
        $display("[TB] round-robin contention done");

        // Watchdog abort on M0
        next_cycle();
        M0_CYC_I = 1; M0_STB_I = 1; M0_ADR_I = 32'h400;
        for (int k = 0; k < 8; k++) begin
            next_cycle(); sample();
            check($sformatf("t4_no_err_%0d", k), M0_ERR_O, 0);
        end
        next_cycle(); sample();
        check("t4_err", M0_ERR_O, 1);
        check("t4_timeout_early", TIMEOUT_O, 0);
        check("t4_scyc_at_err", S_CYC_O, 1);
        next_cycle(); sample();
        check("t4_timeout_pulse", TIMEOUT_O, 1);
        check("t4_abort_scyc", S_CYC_O, 0);
        check("t4_abort_err", M0_ERR_O, 0);
        check("t4_abort_gnt", GNT_O, 2'b01);
        next_cycle();
        S_ACK_I = 1;
        sample();
        check("t4_late_ack", M0_ACK_O, 0);
        check("t4_timeout_end", TIMEOUT_O, 0);
        check("t4_abort_scyc2", S_CYC_O, 0);
        next_cycle();
        S_ACK_I = 0; drop_masters();
        sample();
        check("t4_abort_hold", GNT_O, 2'b01);
        next_cycle(); sample();
        check("t4_idle_gnt", GNT_O, 2'b00);
        $display("[TB] watchdog abort done");

        // ACK on the threshold cycle wins over the abort
        next_cycle();
        M1_CYC_I = 1; M1_STB_I = 1; M1_ADR_I = 32'h500;
        for (int k = 0; k < 8; k++) next_cycle();
        next_cycle();
        S_ACK_I = 1;
        sample();
        check("t5_ack", M1_ACK_O, 1);
        check("t5_err", M1_ERR_O, 0);
        next_cycle();
        S_ACK_I = 0;
        sample();
        check("t5_no_timeout", TIMEOUT_O, 0);
        check("t5_still_grant", GNT_O, 2'b10);
        check("t5_scyc", S_CYC_O, 1);
        next_cycle();
        drop_masters();
        next_cycle();
        $display("[TB] ack/threshold race done");

        // Asynchronous reset during a granted cycle
        next_cycle();
        M1_CYC_I = 1; M1_STB_I = 1;
        next_cycle();
        S_ACK_I = 1;
        sample();
        check("t6_pre_gnt", GNT_O, 2'b10);
        check("t6_pre_ack", M1_ACK_O, 1);
        #2 RST_I = 1'b1;
        #1;
        check("t6_rst_scyc", S_CYC_O, 0);
        check("t6_rst_gnt", GNT_O, 2'b00);
        check("t6_rst_ack", M1_ACK_O, 0);
        S_ACK_I = 0;
        M0_CYC_I = 1; M0_STB_I = 1;
        next_cycle();
        #2 RST_I = 1'b0;
        next_cycle(); sample();
        check("t6_tie_gnt", GNT_O, 2'b01);
        next_cycle();
        drop_masters();
        next_cycle();
        $display("[TB] async reset done");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
